// File: rtl/ballot_controller.sv
// Polling-booth sequencer sitting between officer/voter controls and a voting machine.
// Arms on officer auth, validates a one-hot keypad choice, pulses the machine, shows results.
module ballot_controller #(
    parameter int unsigned HOLD_CYCLES    = 5,
    parameter int unsigned GAP_CYCLES     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 100,
    parameter int unsigned DISP_CYCLES    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       auth,
    input  logic       close_poll,
    input  logic [3:0] vote_sel,
    output logic [3:0] vm_candidate,
    output logic       vm_mode,
    output logic       vm_button,
    output logic       ready,
    output logic       invalid,
    output logic       timeout,
    output logic       vote_done,
    output logic [7:0] total_votes
);

    localparam int unsigned MaxHg  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned MaxTd  = (TIMEOUT_CYCLES > DISP_CYCLES) ? TIMEOUT_CYCLES : DISP_CYCLES;
    localparam int unsigned MaxCyc = (MaxHg > MaxTd) ? MaxHg : MaxTd;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
    localparam logic [CntW-1:0] ArmLast  = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] DispLast = CntW'(DISP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StHold,
        StCooldown,
        StResult
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      cand_q, cand_d;
    logic [7:0]      total_q, total_d;
    logic            invalid_q, invalid_d;
    logic            timeout_q, timeout_d;
    logic            vote_done_q, vote_done_d;
    logic            ready_q, ready_d;
    logic            vm_mode_q, vm_mode_d;
    logic            vm_button_q, vm_button_d;
    logic [3:0]      vm_cand_q, vm_cand_d;

    // cnt_q counts cycles already spent in the current state; it is zeroed on every transition.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CntW'(1);
        cand_d      = cand_q;
        total_d     = total_q;
        invalid_d   = 1'b0;
        timeout_d   = 1'b0;
        vote_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (close_poll) begin
                    state_d = StResult;
                    cand_d  = 4'b0001;
                end else if (auth) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if ($onehot(vote_sel)) begin
                    state_d = StHold;
                    cand_d  = vote_sel;
                    cnt_d   = '0;
                end else begin
                    invalid_d = (vote_sel != 4'b0000);
                    if (cnt_q == ArmLast) begin
                        state_d   = StIdle;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d     = StCooldown;
                    cnt_d       = '0;
                    cand_d      = '0;
                    vote_done_d = 1'b1;
                    if (total_q != 8'hFF) begin
                        total_d = total_q + 8'd1;
                    end
                end
            end
            StCooldown: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StResult: begin
                if (cnt_q == DispLast) begin
                    cnt_d  = '0;
                    cand_d = {cand_q[2:0], cand_q[3]};
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so the registered copies line up with it.
        ready_d     = (state_d == StArmed);
        vm_mode_d   = (state_d == StResult);
        vm_button_d = (state_d == StHold) || (state_d == StResult);
        vm_cand_d   = vm_button_d ? cand_d : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cand_q      <= '0;
            total_q     <= '0;
            invalid_q   <= 1'b0;
            timeout_q   <= 1'b0;
            vote_done_q <= 1'b0;
            ready_q     <= 1'b0;
            vm_mode_q   <= 1'b0;
            vm_button_q <= 1'b0;
            vm_cand_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            total_q     <= total_d;
            invalid_q   <= invalid_d;
            timeout_q   <= timeout_d;
            vote_done_q <= vote_done_d;
            ready_q     <= ready_d;
            vm_mode_q   <= vm_mode_d;
            vm_button_q <= vm_button_d;
            vm_cand_q   <= vm_cand_d;
        end
    end

    assign vm_candidate = vm_cand_q;
    assign vm_mode      = vm_mode_q;
    assign vm_button    = vm_button_q;
    assign ready        = ready_q;
    assign invalid      = invalid_q;
    assign timeout      = timeout_q;
    assign vote_done    = vote_done_q;
    assign total_votes  = total_q;

endmodule

// File: tb/tb_ballot_controller.sv
// Self-checking bench for ballot_controller: directed scenarios plus randomized traffic,
// every cycle compared against a timestamp-based behavioural model.
module tb_ballot_controller;

    localparam int unsigned Hold = 5;
    localparam int unsigned Gap  = 5;
    localparam int unsigned Tmo  = 100;
    localparam int unsigned Disp = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       auth;
    logic       close_poll;
    logic [3:0] vote_sel;
    logic [3:0] vm_candidate;
    logic       vm_mode;
    logic       vm_button;
    logic       ready;
    logic       invalid;
    logic       timeout;
    logic       vote_done;
    logic [7:0] total_votes;

    always #5 clk = ~clk;

    ballot_controller #(
        .HOLD_CYCLES   (Hold),
        .GAP_CYCLES    (Gap),
        .TIMEOUT_CYCLES(Tmo),
        .DISP_CYCLES   (Disp)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .auth        (auth),
        .close_poll  (close_poll),
        .vote_sel    (vote_sel),
        .vm_candidate(vm_candidate),
        .vm_mode     (vm_mode),
        .vm_button   (vm_button),
        .ready       (ready),
        .invalid     (invalid),
        .timeout     (timeout),
        .vote_done   (vote_done),
        .total_votes (total_votes)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: a phase plus the edge index at which it began; outputs follow from elapsed edges.
    typedef enum int {MIdle, MArmed, MHold, MCool, MResult} mphase_e;
    mphase_e     m_phase = MIdle;
    int unsigned edge_n  = 0;
    int unsigned m_start = 0;
    int unsigned m_total = 0;
    logic [3:0]  m_cand  = 4'b0000;
    logic        m_inv, m_to, m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic model_step(input logic rn, input logic a, input logic c, input logic [3:0] s);
        int unsigned age;
        edge_n++;
        age    = edge_n - m_start;
        m_inv  = 1'b0;
        m_to   = 1'b0;
        m_done = 1'b0;
        if (!rn) begin
            m_phase = MIdle;
            m_total = 0;
            m_cand  = 4'b0000;
            m_start = edge_n;
        end else begin
            case (m_phase)
                MIdle: begin
                    if (c) begin
                        m_phase = MResult;
                        m_start = edge_n;
                    end else if (a) begin
                        m_phase = MArmed;
                        m_start = edge_n;
                    end
                end
                MArmed: begin
                    if ($countones(s) == 1) begin
                        m_phase = MHold;
                        m_cand  = s;
                        m_start = edge_n;
                    end else begin
                        m_inv = (s != 4'b0000);
                        if (age == Tmo) begin
                            m_to    = 1'b1;
                            m_phase = MIdle;
                            m_start = edge_n;
                        end
                    end
                end
                MHold: begin
                    if (age == Hold) begin
                        m_done  = 1'b1;
                        m_phase = MCool;
                        m_start = edge_n;
                        if (m_total < 255) m_total++;
                    end
                end
                MCool: begin
                    if (age == Gap) begin
                        m_phase = MIdle;
                        m_start = edge_n;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_outputs();
        int unsigned age;
        logic [3:0]  one;
        logic [3:0]  exp_cand;
        logic [1:0]  exp_mb;
        age      = edge_n - m_start;
        one      = 4'b0001;
        exp_cand = 4'b0000;
        exp_mb   = 2'b00;
        if (m_phase == MHold) begin
            exp_cand = m_cand;
            exp_mb   = 2'b01;
        end else if (m_phase == MResult) begin
            exp_cand = one << ((age / Disp) % 4);
            exp_mb   = 2'b11;
        end
        check("candidate", 32'(vm_candidate), 32'(exp_cand));
        check("mode_button", 32'({vm_mode, vm_button}), 32'(exp_mb));
        check("ready_pulses", 32'({ready, invalid, timeout, vote_done}),
              32'({m_phase == MArmed, m_inv, m_to, m_done}));
        check("total_votes", 32'(total_votes), m_total);
    endtask

    // Inputs change just after the falling edge; outputs are sampled at the next falling edge.
    task automatic cycle(input logic rn, input logic a, input logic c, input logic [3:0] s);
        reset      = rn;
        auth       = a;
        close_poll = c;
        vote_sel   = s;
        @(posedge clk);
        model_step(rn, a, c, s);
        @(negedge clk);
        compare_outputs();
    endtask

    function automatic logic [3:0] rand_onehot();
        logic [3:0] one;
        one = 4'b0001;
        return one << $urandom_range(0, 3);
    endfunction

    function automatic logic [3:0] rand_noise();
        logic [3:0] v;
        v = 4'($urandom_range(0, 15));
        if ($countones(v) == 1) v = 4'b0000;
        return v;
    endfunction

    initial begin
        // Reset, then a clean vote for candidate 0100 two cycles after auth.
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 4'b0000);
        check("reset_total", 32'(total_votes), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 4'b0000);
        check("ready_after_auth", 32'(ready), 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 4'b0000);
        cycle(1'b1, 1'b0, 1'b0, 4'b0100);
        repeat (Hold + Gap + 2) cycle(1'b1, 1'b0, 1'b0, 4'b0000);
        check("first_vote_total", 32'(total_votes), 32'd1);

        // Two malformed selections followed by a valid one.
        cycle(1'b1, 1'b1, 1'b0, 4'b0000);
        cycle(1'b1, 1'b0, 1'b0, 4'b0011);
        cycle(1'b1, 1'b0, 1'b0, 4'b0111);
        cycle(1'b1, 1'b0, 1'b0, 4'b0010);
        repeat (Hold + Gap + 1) cycle(1'b1, 1'b0, 1'b0, 4'b0000);

        // Armed booth left untouched until the timeout fires.
        cycle(1'b1, 1'b1, 1'b0, 4'b0000);
        repeat (Tmo + 4) cycle(1'b1, 1'b0, 1'b0, 4'b0000);
        check("after_timeout_ready", 32'(ready), 32'd0);

        // Keypad churn during HOLD and officer inputs during COOLDOWN are ignored.
        cycle(1'b1, 1'b1, 1'b0, 4'b0000);
        cycle(1'b1, 1'b0, 1'b0, 4'b1000);
        repeat (Hold) cycle(1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
        repeat (Gap) cycle(1'b1, 1'b1, 1'b0, 4'($urandom_range(0, 15)));
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 4'b0000);

        // Reset in the middle of HOLD aborts the vote.
        cycle(1'b1, 1'b1, 1'b0, 4'b0000);
        cycle(1'b1, 1'b0, 1'b0, 4'b0001);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 4'b0000);
        cycle(1'b0, 1'b0, 1'b0, 4'b0000);
        repeat (Hold + 2) cycle(1'b1, 1'b0, 1'b0, 4'b0000);

        // Enough committed votes to saturate the counter, with random noise around each.
        for (int v = 0; v < 262; v++) begin
            cycle(1'b1, 1'b1, 1'b0, 4'b0000);
            repeat ($urandom_range(0, 3)) cycle(1'b1, 1'b0, 1'b0, rand_noise());
            cycle(1'b1, 1'b0, 1'b0, rand_onehot());
            repeat (Hold + Gap) cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                      4'($urandom_range(0, 15)));
        end
        check("saturated_total", 32'(total_votes), 32'd255);

        // Free-running random traffic with occasional resets and poll closures.
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
        end

        // close_poll wins over auth from IDLE; result display rotates and never exits.
        cycle(1'b0, 1'b0, 1'b0, 4'b0000);
        cycle(1'b1, 1'b1, 1'b1, 4'b0000);
        check("result_first_cand", 32'(vm_candidate), 32'd1);
        repeat (4 * Disp + 12) cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                     4'($urandom_range(0, 15)));
        check("result_mode", 32'(vm_mode), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
